// File: rtl/core_dbus_bridge_pkg.sv
// core_dbus_bridge_pkg
//   Shared types for the core data-bus path.
//   word          : 32-bit data word
//   ptr           : 30-bit word address (byte address >> 2)
//   dbus_state    : bridge FSM states
//   DBUS_ERR_WORD : load data returned when an access is aborted by timeout
package core_dbus_bridge_pkg;

  typedef logic [31:0] word;
  typedef logic [29:0] ptr;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } dbus_state;

  localparam word DBUS_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/core_dbus_bridge.sv
// core_dbus_bridge
//   Bridges the core's single-outstanding data port (start/ready pulses,
//   word address) onto an Avalon-MM pipelined master with waitrequest and
//   readdatavalid. One transaction in flight at a time; all outputs are
//   registered.
//
//   Optional build macro: CORE_DBUS_TIMEOUT_EN
//     Adds a command-to-completion watchdog of TIMEOUT cycles. On expiry the
//     command is dropped, data_ready pulses (loads return DBUS_ERR_WORD) and
//     the sticky bus_error flag is set. Without the macro the bridge waits
//     forever and bus_error is tied low.
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     data_start          : one-cycle request pulse (addr/write/wr/be valid)
//     data_addr           : word address
//     data_write          : 1 = store, 0 = load
//     data_data_wr/_be    : store data / byte enables
//     data_ready          : one-cycle completion pulse
//     data_data_rd        : load data, held until the next load completes
//     avl_*               : Avalon-MM master
//     bus_error           : sticky timeout flag
module core_dbus_bridge
  import core_dbus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_start,
  input  ptr          data_addr,
  input  logic        data_write,
  input  word         data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output word         data_data_rd,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output word         avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  word         avl_readdata,
  input  logic        avl_readdatavalid,
  output logic        bus_error
);

  dbus_state state_reg;
  logic      done_now;     // access completes at the coming edge
  logic      timeout_hit;  // watchdog expired (never with the feature off)
  logic      abort_now;

  // A write completes when its command is accepted; a read when its data
  // arrives. Completion wins over a coincident timeout.
  assign done_now  = (state_reg == CMD  && !avl_waitrequest && avl_write) ||
                     (state_reg == RESP && avl_readdatavalid);
  assign abort_now = timeout_hit && !done_now;

`ifdef CORE_DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_reg;

  // Held at zero in IDLE, so it starts from zero on entry to CMD and counts
  // every cycle spent in CMD and RESP.
  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) begin
      tmo_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
    end
  end

  // Expires during the TIMEOUT-th busy cycle.
  assign timeout_hit = (state_reg != IDLE) && (tmo_cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_error <= 1'b0;
    end else if (abort_now) begin
      bus_error <= 1'b1;
    end
  end
`else
  // TIMEOUT only matters with the watchdog; this keeps it referenced.
  assign timeout_hit = (TIMEOUT < 0);
  assign bus_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      data_ready   <= 1'b0;
      data_data_rd <= '0;
      avl_read     <= 1'b0;
      avl_write    <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_start) begin
            avl_address    <= {data_addr, 2'b00};
            avl_writedata  <= data_data_wr;
            avl_byteenable <= data_data_be;
            avl_read       <= !data_write;
            avl_write      <= data_write;
            state_reg      <= CMD;
          end
        end
        CMD: begin
          if (!avl_waitrequest) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            if (avl_write) begin
              data_ready <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              state_reg  <= RESP;
            end
          end else if (abort_now) begin
            avl_read   <= 1'b0;
            avl_write  <= 1'b0;
            data_ready <= 1'b1;
            if (avl_read) data_data_rd <= DBUS_ERR_WORD;
            state_reg  <= IDLE;
          end
        end
        RESP: begin
          if (avl_readdatavalid) begin
            data_data_rd <= avl_readdata;
            data_ready   <= 1'b1;
            state_reg    <= IDLE;
          end else if (abort_now) begin
            data_data_rd <= DBUS_ERR_WORD;
            data_ready   <= 1'b1;
            state_reg    <= IDLE;
          end
        end
        default: begin
          avl_read  <= 1'b0;
          avl_write <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The upstream stage must hold off until data_ready; a start while busy
  // is dropped, and this flags the protocol error.
  a_start_only_idle : assert property (
    @(posedge clk) disable iff (rst) !(data_start && state_reg != IDLE)
  ) else $warning("core_dbus_bridge: data_start while busy, request dropped");
`endif

endmodule

// File: doc/core_dbus_bridge.md
Name: core_dbus_bridge

Overview:
- Downstream neighbour of the core load/store stage.
- Converts the core's single-outstanding data port (start pulse / ready pulse, word address) into an Avalon-MM pipelined master.
- Master supports waitrequest and readdatavalid; it sits between the core and the data interconnect.
- Exactly one transaction is in flight at a time; the upstream stage holds off new requests until ready.

Parameters:
- TIMEOUT, 255, bus cycles allowed from command issue to completion before abort (used only with CORE_DBUS_TIMEOUT_EN); counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock; all logic is posedge clk.
- rst  in  1  synchronous reset, active-high.
- data_start  in  1  one-cycle request pulse; addr/write/wr/be are valid in this cycle.
- data_addr  in  30  word address (ptr).
- data_write  in  1  1 = store, 0 = load.
- data_data_wr  in  32  store data.
- data_data_be  in  4  byte enables.
- data_ready  out  1  one-cycle completion pulse.
- data_data_rd  out  32  load data; valid while data_ready=1 and held until the next load completes.
- avl_address  out  32  byte address {data_addr,2'b00}.
- avl_read  out  1  Avalon read command.
- avl_write  out  1  Avalon write command.
- avl_writedata  out  32  Avalon write data.
- avl_byteenable  out  4  Avalon byte enables.
- avl_waitrequest  in  1  slave stall; command is held while this is 1.
- avl_readdata  in  32  read data.
- avl_readdatavalid  in  1  read data strobe.
- bus_error  out  1  sticky timeout flag, cleared only by rst.

Behaviour:
- Reset values: state IDLE; data_ready=0, avl_read=0, avl_write=0, bus_error=0, data_data_rd=0. avl_address, avl_writedata and avl_byteenable are don't-care.
- All outputs are registered.
- FSM states: IDLE, CMD, RESP.
- IDLE, on data_start: capture address, write, write data and byte enables into the Avalon registers. Set avl_read = !data_write and avl_write = data_write. Go to CMD.
- CMD, avl_waitrequest=1: hold all command outputs unchanged.
- CMD, avl_waitrequest=0: the command is accepted this cycle; drop avl_read and avl_write.
  - For a write: data_ready=1 next cycle, go to IDLE.
  - For a read: go to RESP.
- RESP, avl_readdatavalid=1: data_data_rd <= avl_readdata, data_ready=1 next cycle, go to IDLE.
- Minimum latency, start at cycle T:
  - Command asserted at T+1.
  - Write: data_ready at T+2.
  - Read: readdatavalid at T+2 earliest, data_ready at T+3.
- data_ready is high for exactly one cycle per transaction.
- data_start outside IDLE is ignored. A simulation-only assertion flags it as a protocol error.
- avl_readdatavalid in IDLE or CMD is ignored; this covers stray or late responses, including those after reset.
- A new data_start is accepted in the same cycle data_ready is high, since the FSM is already in IDLE.
- Reset mid-transaction: the next edge returns to IDLE and deasserts commands. No data_ready is produced for the aborted access.

Optional Feature:
- Macro: CORE_DBUS_TIMEOUT_EN.
- With the macro:
  - Counter clears on entry to CMD and increments each cycle in CMD and RESP.
  - When it reaches TIMEOUT: drop commands, go to IDLE, pulse data_ready with data_data_rd=32'hDEAD_BEEF for reads, and set bus_error.
- Without the macro:
  - No counter; the FSM waits indefinitely.
  - bus_error is tied to 0.

Decomposition:
- Use word and ptr from the core uarch package.
- Add the enum dbus_state {IDLE,CMD,RESP} and the constant DBUS_ERR_WORD=32'hDEAD_BEEF to that package.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Read, zero waits: data_start, addr=30'h100, write=0; readdatavalid one cycle after acceptance with readdata=32'h1234_5678 -> avl_address=32'h400, avl_read for 1 cycle; data_ready at T+3 with data_data_rd=32'h1234_5678.
- Write with 3 waitrequest cycles: data_data_wr=32'hCAFE_F00D, be=4'hF -> avl_write plus stable address/data/be for 4 cycles; data_ready single pulse 1 cycle after acceptance; data_data_rd unchanged.
- Back-to-back: new data_start in the cycle data_ready is high -> second command issued on the next cycle; stray readdatavalid in IDLE leaves data_data_rd unchanged and produces no data_ready.
- Reset in RESP, then readdatavalid arrives -> no data_ready, all commands 0, bus_error 0.
- CORE_DBUS_TIMEOUT_EN, TIMEOUT=8, slave holds waitrequest=1 -> command dropped after 8 cycles; data_ready pulse with 32'hDEAD_BEEF; bus_error=1 until rst.
- data_start while in CMD -> ignored; captured command unchanged; assertion fires.
